// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard / stall / flush controller for a 5-stage pipeline.
//
// Purpose:
//   Generates the PC and pipeline-register write enables and the bubble
//   (flush) controls from a small FSM (BOOT, RUN, MEMWAIT, HALT, ERR) and the
//   hazard inputs from decode, execute, memory and writeback.
//   All control outputs are combinational from the current state and inputs.
//   MEMWAIT runs an 8-bit watchdog. When the watchdog expires, the FSM goes
//   to the terminal ERR state.
//
// Ports:
//   clk          in   1   pipeline clock, rising edge
//   rst          in   1   asynchronous active-low reset
//   id_rs/id_rt  in   4   decode source register numbers
//   id_uses_rs/rt in  1   decode instruction reads rs / rt
//   ex_lw        in   1   execute instruction is a load word
//   ex_rd        in   4   execute destination register
//   ex_br_taken  in   1   execute branch/jump resolved taken
//   mem_busy     in   1   data memory not ready
//   wb_hlt       in   1   halt instruction in writeback
//   pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out 1  write enables
//   if_id_flush, id_ex_flush                         out 1  bubble loads
//   halted, err  out  1   status (HALT / ERR state)
//   ctrl_state   out  3   BOOT=0 RUN=1 MEMWAIT=2 HALT=3 ERR=4
//
// Optional feature (macro PIPE_CTRL_PERF_EN):
//   Adds the saturating 16-bit outputs stall_cnt and flush_cnt.
// -----------------------------------------------------------------------------
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_lw,
  input  logic [3:0] ex_rd,
  input  logic       ex_br_taken,
  input  logic       mem_busy,
  input  logic       wb_hlt,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       id_ex_we,
  output logic       ex_mem_we,
  output logic       mem_wb_we,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       halted,
  output logic       err,
  output logic [2:0] ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_RUN     = 3'd1,
    ST_MEMWAIT = 3'd2,
    ST_HALT    = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] wd_r;
  logic [7:0] wd_nxt_s;
  logic       load_use_s;
  logic       run_rules_s;

  // Load-use hazard: register 0 is hard-wired, so a load into it never stalls.
  assign load_use_s = ex_lw && (ex_rd != 4'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

  // RUN rules also apply in the MEMWAIT cycle where memory becomes ready.
  assign run_rules_s = (state_r == ST_RUN) ||
                       ((state_r == ST_MEMWAIT) && !mem_busy);

  // Next-state, watchdog and write-enable/flush decode.
  always_comb begin
    state_nxt_s = state_r;
    wd_nxt_s    = wd_r;
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    id_ex_we    = 1'b0;
    ex_mem_we   = 1'b0;
    mem_wb_we   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_RUN;
        wd_nxt_s    = 8'd0;
      end
      ST_RUN, ST_MEMWAIT: begin
        if (!run_rules_s) begin
          // Still waiting on memory: everything frozen, watchdog counting.
          if (wd_r == 8'd255) begin
            state_nxt_s = ST_ERR;
          end else begin
            wd_nxt_s = wd_r + 8'd1;
          end
        end else if (wb_hlt) begin
          state_nxt_s = ST_HALT;
          wd_nxt_s    = 8'd0;
        end else if (mem_busy) begin
          // A taken branch seen here stays in execute (frozen) and is
          // serviced on the first non-busy cycle.
          state_nxt_s = ST_MEMWAIT;
          wd_nxt_s    = 8'd1;
        end else if (ex_br_taken) begin
          state_nxt_s = ST_RUN;
          wd_nxt_s    = 8'd0;
          pc_we       = 1'b1;
          if_id_we    = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use_s) begin
          // Hold PC and IF/ID, inject a bubble into ID/EX; the load moves on.
          state_nxt_s = ST_RUN;
          wd_nxt_s    = 8'd0;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
          id_ex_flush = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
          wd_nxt_s    = 8'd0;
          pc_we       = 1'b1;
          if_id_we    = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      ST_ERR: begin
        state_nxt_s = ST_ERR;
      end
      default: begin
        // Illegal encoding: park in the safe terminal error state.
        state_nxt_s = ST_ERR;
      end
    endcase
  end

  // State and watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_BOOT;
      wd_r    <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      wd_r    <= wd_nxt_s;
    end
  end

  assign ctrl_state = state_r;
  assign halted     = (state_r == ST_HALT);
  assign err        = (state_r == ST_ERR);

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;
  logic        stall_inc_s;
  logic        flush_inc_s;

  assign stall_inc_s = ((state_r == ST_RUN) || (state_r == ST_MEMWAIT)) && !pc_we;
  assign flush_inc_s = run_rules_s && if_id_flush;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      if (stall_inc_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
      if (flush_inc_s && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl.
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit
// later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_lw, ex_br_taken, mem_busy, wb_hlt;
  logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic       if_id_flush, id_ex_flush, halted, err;
  logic [2:0] ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  logic [4:0] we_v;
  logic [1:0] fl_v;
  assign we_v = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we};
  assign fl_v = {if_id_flush, id_ex_flush};

  int total = 0;
  int bad   = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_lw(ex_lw), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .mem_busy(mem_busy), .wb_hlt(wb_hlt),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .err(err), .ctrl_state(ctrl_state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_in();
    id_rs = 4'd0; id_rt = 4'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_lw = 1'b0; ex_rd = 4'd0; ex_br_taken = 1'b0; mem_busy = 1'b0; wb_hlt = 1'b0;
  endtask

  // Reset pulse placed between edges, then one BOOT cycle into RUN.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    clr_in();
    #2;
    // ---- reset state
    chk("rst_state", 32'(ctrl_state), 32'd0);
    chk("rst_we", 32'(we_v), 32'h00);
    chk("rst_fl", 32'(fl_v), 32'h0);
    chk("rst_flags", 32'({halted, err}), 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_cnt", {stall_cnt, flush_cnt}, 32'h0);
`endif
    tick();
    rst = 1'b1;
    #1;
    chk("boot_state", 32'(ctrl_state), 32'd0);
    chk("boot_we", 32'(we_v), 32'h00);
    tick();
    #1;
    chk("run_state", 32'(ctrl_state), 32'd1);
    chk("run_we", 32'(we_v), 32'h1F);
    chk("run_fl", 32'(fl_v), 32'h0);

    // ---- load-use on r0 does not stall
    ex_lw = 1'b1; ex_rd = 4'd0; id_uses_rs = 1'b1; id_rs = 4'd0;
    #1;
    chk("lu_r0_we", 32'(we_v), 32'h1F);
    // ---- load-use on r3 via rs
    ex_rd = 4'd3; id_rs = 4'd3;
    #1;
    chk("lu_rs_we", 32'(we_v), 32'h07);
    chk("lu_rs_fl", 32'(fl_v), 32'h1);
    tick();
    ex_lw = 1'b0;
    #1;
    chk("lu_after_state", 32'(ctrl_state), 32'd1);
    chk("lu_after_we", 32'(we_v), 32'h1F);
    chk("lu_after_fl", 32'(fl_v), 32'h0);
    // ---- rt path: match only matters when rt is actually read
    ex_lw = 1'b1; ex_rd = 4'd5; id_uses_rs = 1'b0; id_rs = 4'd5; id_rt = 4'd5;
    #1;
    chk("lu_nouse_we", 32'(we_v), 32'h1F);
    id_uses_rt = 1'b1;
    #1;
    chk("lu_rt_we", 32'(we_v), 32'h07);
    // ---- branch outranks load-use
    ex_br_taken = 1'b1;
    #1;
    chk("br_lu_we", 32'(we_v), 32'h1F);
    chk("br_lu_fl", 32'(fl_v), 32'h3);
    tick();
    clr_in();
    #1;
    chk("br_after_fl", 32'(fl_v), 32'h0);
    chk("br_after_state", 32'(ctrl_state), 32'd1);

    // ---- branch masked by memory stall, busy for 3 cycles
    ex_br_taken = 1'b1; mem_busy = 1'b1;
    #1;
    chk("brm_c0_we", 32'(we_v), 32'h00);
    chk("brm_c0_fl", 32'(fl_v), 32'h0);
    tick();
    #1;
    chk("brm_c1_state", 32'(ctrl_state), 32'd2);
    chk("brm_c1_wefl", 32'({we_v, fl_v}), 32'h0);
    tick();
    tick();
    mem_busy = 1'b0;
    #1;
    chk("brm_rel_state", 32'(ctrl_state), 32'd2);
    chk("brm_rel_we", 32'(we_v), 32'h1F);
    chk("brm_rel_fl", 32'(fl_v), 32'h3);
    tick();
    ex_br_taken = 1'b0;
    #1;
    chk("brm_back_state", 32'(ctrl_state), 32'd1);
    chk("brm_back_fl", 32'(fl_v), 32'h0);

    // ---- watchdog: busy released at cycle 200 returns to RUN
    mem_busy = 1'b1;
    for (int i = 1; i < 200; i++) tick();
    #1;
    chk("wd199_state", 32'(ctrl_state), 32'd2);
    tick();
    mem_busy = 1'b0;
    #1;
    chk("wd200_state", 32'(ctrl_state), 32'd2);
    chk("wd200_we", 32'(we_v), 32'h1F);
    tick();
    #1;
    chk("wd200_run", 32'(ctrl_state), 32'd1);

    // ---- watchdog: busy held -> ERR 256 cycles after the first busy cycle
    mem_busy = 1'b1;
    repeat (255) tick();
    #1;
    chk("wd255_state", 32'(ctrl_state), 32'd2);
    tick();
    #1;
    chk("wd256_state", 32'(ctrl_state), 32'd4);
    chk("wd256_flags", 32'({halted, err}), 32'h1);
    chk("wd256_we", 32'({we_v, fl_v}), 32'h0);
    mem_busy = 1'b0; ex_br_taken = 1'b1;
    tick();
    #1;
    chk("err_sticky", 32'({ctrl_state, err, we_v, fl_v}), 32'({3'd4, 1'b1, 7'd0}));
    rst = 1'b0;
    #1;
    chk("err_rst_state", 32'(ctrl_state), 32'd0);
    chk("err_rst_err", 32'(err), 32'd0);
    clr_in();
    tick();
    rst = 1'b1;
    tick();
    #1;
    chk("err_rst_run", 32'(ctrl_state), 32'd1);

    // ---- reset during a memory stall
    mem_busy = 1'b1;
    tick();
    #1;
    chk("ms_state", 32'(ctrl_state), 32'd2);
    rst = 1'b0;
    #1;
    chk("ms_rst_state", 32'(ctrl_state), 32'd0);
    chk("ms_rst_we", 32'(we_v), 32'h00);
    clr_in();
    tick();
    rst = 1'b1;
    tick();
    #1;
    chk("ms_rst_run", 32'(ctrl_state), 32'd1);

`ifdef PIPE_CTRL_PERF_EN
    // ---- perf counters: 2 load-use stalls, 1 branch, memory stall of one
    // RUN cycle plus 4 MEMWAIT cycles -> 7 stall cycles, 1 flush
    do_reset();
    chk("perf_zero", {stall_cnt, flush_cnt}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      ex_lw = 1'b1; ex_rd = 4'd7; id_uses_rs = 1'b1; id_rs = 4'd7;
      tick();
      clr_in();
      tick();
    end
    ex_br_taken = 1'b1;
    tick();
    ex_br_taken = 1'b0;
    tick();
    mem_busy = 1'b1;
    repeat (5) tick();
    mem_busy = 1'b0;
    tick();
    #1;
    chk("perf_stall", 32'(stall_cnt), 32'd7);
    chk("perf_flush", 32'(flush_cnt), 32'd1);
    do_reset();
`endif

    // ---- halt outranks memory busy and branch
    wb_hlt = 1'b1; mem_busy = 1'b1; ex_br_taken = 1'b1;
    #1;
    chk("hlt_c0_we", 32'(we_v), 32'h00);
    chk("hlt_c0_state", 32'(ctrl_state), 32'd1);
    tick();
    wb_hlt = 1'b0; mem_busy = 1'b0;
    for (int c = 0; c < 50; c++) begin
      #1;
      chk("hlt_hold", 32'({ctrl_state, halted, err, we_v, fl_v}),
          32'({3'd3, 1'b1, 1'b0, 7'd0}));
      tick();
    end
    rst = 1'b0;
    #1;
    chk("hlt_rst_halted", 32'(halted), 32'd0);
    chk("hlt_rst_state", 32'(ctrl_state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
